ssd_capture: RTL

Seven-segment display bus monitor: samples the multiplexed, active-low segment/anode lines produced by the display driver and reconstructs the displayed hex digits. Each digit is decoded only after its pattern has been stable for a programmable number of cycles, and every unrecognized pattern or illegal anode combination is flagged. The block sits beside the display driver for on-chip loopback checking and debug readback of what the board is actually showing.

---
 rtl/ssd_capture.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ssd_capture.sv
// ssd_capture: seven-segment bus monitor.
// Rebuilds displayed hex digits from the multiplexed active-low seg/an lines.
module ssd_capture #(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [6:0]            seg,
   input  logic [DIGITS-1:0]     an,
   output logic [4*DIGITS-1:0]   value,
   output logic [DIGITS-1:0]     digit_valid,
   output logic                  frame_done,
   output logic                  err
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] SAT = CW'(STABLE_CYCLES);

   logic [6:0]        seg_q, seg_p;
   logic [DIGITS-1:0] an_q, an_p;
   logic [CW-1:0]     cnt, run;
   logic              done, same, commit;
   logic [DIGITS-1:0] sel, seen, seen_set;
   logic [IW-1:0]     idx;
   logic [6:0]        lit;
   logic [4:0]        dec;
   logic              none, multi, blank, ok, bad;

   function automatic logic [4:0] decode(input logic [6:0] p);
      case (p)
         7'h3F:   decode = 5'h10;
         7'h06:   decode = 5'h11;
         7'h5B:   decode = 5'h12;
         7'h4F:   decode = 5'h13;
         7'h66:   decode = 5'h14;
         7'h6D:   decode = 5'h15;
         7'h7D:   decode = 5'h16;
         7'h07:   decode = 5'h17;
         7'h7F:   decode = 5'h18;
         7'h6F:   decode = 5'h19;
         7'h77:   decode = 5'h1A;
         7'h7C:   decode = 5'h1B;
         7'h39:   decode = 5'h1C;
         7'h5E:   decode = 5'h1D;
         7'h79:   decode = 5'h1E;
         7'h71:   decode = 5'h1F;
         default: decode = 5'h00;
      endcase
   endfunction

   // Run length of the current sample; commit once when it reaches the target.
   always_comb begin
      same = ({seg_q, an_q} == {seg_p, an_p});
      if (!same)
         run = CW'(1);
      else if (cnt == SAT)
         run = SAT;
      else
         run = cnt + CW'(1);
      commit = (run == SAT) && !(same && done);
   end

   // Classify the sampled pattern into mutually exclusive cases.
   always_comb begin
      sel   = ~an_q;
      lit   = ~seg_q;
      dec   = decode(lit);
      idx   = '0;
      for (int i = 0; i < DIGITS; i++)
         if (sel[i]) idx = IW'(i);
      none  = ~|sel;
      multi = |(sel & (sel - DIGITS'(1)));
      blank = ~none & ~multi & (lit == 7'h00);
      ok    = ~none & ~multi & dec[4];
      bad   = ~none & ~multi & ~blank & ~dec[4];
      seen_set = seen | (DIGITS'(1) << idx);
   end

   // Input sampling and stability tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_q <= '1;
         an_q  <= '1;
         seg_p <= '1;
         an_p  <= '1;
         cnt   <= '0;
         done  <= 1'b0;
      end else begin
         seg_q <= seg;
         an_q  <= an;
         seg_p <= seg_q;
         an_p  <= an_q;
         cnt   <= run;
         done  <= commit | (same & done);
      end
   end

   // Apply a commit to the digit state, frame tracking and pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         value       <= '0;
         digit_valid <= '0;
         seen        <= '0;
         frame_done  <= 1'b0;
         err         <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         err        <= 1'b0;
         if (commit) begin
            unique case (1'b1)
               none: ;
               multi: err <= 1'b1;
               blank: digit_valid[idx] <= 1'b0;
               ok: begin
                  value[4*idx +: 4] <= dec[3:0];
                  digit_valid[idx]  <= 1'b1;
                  if (&seen_set) begin
                     frame_done <= 1'b1;
                     seen       <= '0;
                  end else begin
                     seen <= seen_set;
                  end
               end
               bad: begin
                  err              <= 1'b1;
                  digit_valid[idx] <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
